// File: rtl/seq_divider.sv
// seq_divider: multi-cycle integer divider, 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one quotient bit per clock using a non-restoring core.
//
// Ports:
//   clock        sole clock, rising edge
//   reset        asynchronous, active-high
//   start        request, sampled only while idle (done=1)
//   signed_mode  1 = two's-complement operands, sampled with start
//   numerator    2*WIDTH-bit dividend, sampled with start
//   denominator  WIDTH-bit divisor, sampled with start
//   quotient     WIDTH-bit result, held until the next result is written
//   remainder    WIDTH-bit result, held until the next result is written
//   done         1 = idle with result valid, 0 = busy
//   div_zero     last operation had a zero divisor
//   overflow     last operation's quotient did not fit in WIDTH bits
//
// Latency is fixed: done returns on the (WIDTH+3)-th edge after acceptance.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [2*WIDTH-1:0]   numerator,
  input  logic [WIDTH-1:0]     denominator,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 done,
  output logic                 div_zero,
  output logic                 overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t state;

  // captured operands
  logic [2*WIDTH-1:0] n_raw;
  logic [WIDTH-1:0]   d_raw;
  logic               smode;

  // iteration state: part is the signed partial remainder, qsh holds the
  // unconsumed dividend bits and collects quotient bits from the bottom
  logic [WIDTH:0]     part;
  logic [WIDTH-1:0]   qsh;
  logic [WIDTH-1:0]   dvs;
  logic               q_neg;
  logic               r_neg;
  logic               err_zero;
  logic               err_ovf;
  logic [CW-1:0]      cnt;

  // final results staged between FIX and DONE
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_r;
  logic               res_dz;
  logic               res_ov;

  logic [2*WIDTH-1:0] n_mag;
  logic [WIDTH-1:0]   d_mag;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     step;
  logic [WIDTH-1:0]   rem_mag;
  logic               ovf_fix;

  always_comb begin
    n_mag = n_raw;
    if (smode && n_raw[2*WIDTH-1]) n_mag = -n_raw;
    d_mag = d_raw;
    if (smode && d_raw[WIDTH-1]) d_mag = -d_raw;

    // The MSB of part is dropped by the shift: the true value of the next
    // partial remainder always lies in [-|D|, |D|), so WIDTH+1-bit modular
    // arithmetic yields it exactly and its MSB is the true sign.
    shifted = {part[WIDTH-1:0], qsh[WIDTH-1]};
    step    = part[WIDTH] ? shifted + {1'b0, dvs} : shifted - {1'b0, dvs};

    rem_mag = part[WIDTH] ? part[WIDTH-1:0] + dvs : part[WIDTH-1:0];

    // a negative result may reach magnitude 2^(WIDTH-1), a positive one not
    ovf_fix = err_ovf || (smode && (q_neg ? (qsh > HALF) : (qsh >= HALF)));

    done = (state == IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      n_raw     <= '0;
      d_raw     <= '0;
      smode     <= 1'b0;
      part      <= '0;
      qsh       <= '0;
      dvs       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      err_zero  <= 1'b0;
      err_ovf   <= 1'b0;
      cnt       <= '0;
      res_q     <= '0;
      res_r     <= '0;
      res_dz    <= 1'b0;
      res_ov    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_raw <= numerator;
            d_raw <= denominator;
            smode <= signed_mode;
            state <= PREP;
          end
        end
        PREP: begin
          dvs      <= d_mag;
          part     <= {1'b0, n_mag[2*WIDTH-1:WIDTH]};
          qsh      <= n_mag[WIDTH-1:0];
          q_neg    <= smode && (n_raw[2*WIDTH-1] ^ d_raw[WIDTH-1]);
          r_neg    <= smode && n_raw[2*WIDTH-1];
          err_zero <= (d_mag == '0);
          err_ovf  <= (n_mag[2*WIDTH-1:WIDTH] >= d_mag);
          cnt      <= '0;
          state    <= ITER;
        end
        ITER: begin
          // NOT(new sign) is the restoring-equivalent quotient bit, so the
          // collected bits are the final magnitude quotient as they stand.
          part <= step;
          qsh  <= {qsh[WIDTH-2:0], ~step[WIDTH]};
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          res_dz <= err_zero;
          res_ov <= !err_zero && ovf_fix;
          if (err_zero) begin
            res_q <= '1;
            res_r <= n_raw[WIDTH-1:0];
          end else if (ovf_fix) begin
            res_q <= '1;
            res_r <= '0;
          end else begin
            res_q <= q_neg ? -qsh : qsh;
            res_r <= r_neg ? -rem_mag : rem_mag;
          end
          state <= DONE;
        end
        DONE: begin
          quotient  <= res_q;
          remainder <= res_r;
          div_zero  <= res_dz;
          overflow  <= res_ov;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int WA = 32;
  localparam int WB = 8;
  localparam int RAND_CYCLES = 50000;

  logic clock;
  logic reset;

  logic          start_a, sm_a;
  logic [63:0]   num_a;
  logic [31:0]   den_a;
  logic [31:0]   q_a, r_a;
  logic          done_a, dz_a, ov_a;

  logic          start_b, sm_b;
  logic [15:0]   num_b;
  logic [7:0]    den_b;
  logic [7:0]    q_b, r_b;
  logic          done_b, dz_b, ov_b;

  int tests;
  int failed;
  bit checking;

  seq_divider #(.WIDTH(WA)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .signed_mode(sm_a),
    .numerator(num_a), .denominator(den_a), .quotient(q_a), .remainder(r_a),
    .done(done_a), .div_zero(dz_a), .overflow(ov_a)
  );

  seq_divider #(.WIDTH(WB)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .signed_mode(sm_b),
    .numerator(num_b), .denominator(den_b), .quotient(q_b), .remainder(r_b),
    .done(done_b), .div_zero(dz_b), .overflow(ov_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // uniform views of both DUTs for the model and the compare process
  logic         in_start [2];
  logic         in_sm    [2];
  logic [127:0] in_num   [2];
  logic [63:0]  in_den   [2];
  logic [63:0]  out_q    [2];
  logic [63:0]  out_r    [2];
  logic         out_done [2];
  logic         out_dz   [2];
  logic         out_ov   [2];

  assign in_start[0] = start_a;          assign in_start[1] = start_b;
  assign in_sm[0]    = sm_a;             assign in_sm[1]    = sm_b;
  assign in_num[0]   = {64'b0, num_a};   assign in_num[1]   = {112'b0, num_b};
  assign in_den[0]   = {32'b0, den_a};   assign in_den[1]   = {56'b0, den_b};
  assign out_q[0]    = {32'b0, q_a};     assign out_q[1]    = {56'b0, q_b};
  assign out_r[0]    = {32'b0, r_a};     assign out_r[1]    = {56'b0, r_b};
  assign out_done[0] = done_a;           assign out_done[1] = done_b;
  assign out_dz[0]   = dz_a;             assign out_dz[1]   = dz_b;
  assign out_ov[0]   = ov_a;             assign out_ov[1]   = ov_b;

  function automatic int wid(input int i);
    return (i == 0) ? WA : WB;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: plain signed division on wide integers.
  function automatic void ref_div(input int w, input bit sm, input logic [127:0] n_in,
                                  input logic [63:0] d_in, output logic [63:0] q,
                                  output logic [63:0] r, output bit dz, output bit ov);
    logic signed [131:0] one, m2, mw, nv, dv, qt, rt, lo, hi;
    one = 132'sd1;
    m2  = (one <<< (2*w)) - one;
    mw  = (one <<< w) - one;
    nv  = $signed({4'b0, n_in}) & m2;
    dv  = $signed({68'b0, d_in}) & mw;
    if (sm && nv[2*w-1]) nv = nv - (one <<< (2*w));
    if (sm && dv[w-1])   dv = dv - (one <<< w);
    dz = 1'b0;
    ov = 1'b0;
    if (dv == 0) begin
      dz = 1'b1;
      q  = 64'(mw);
      r  = 64'($signed({4'b0, n_in}) & mw);
    end else begin
      qt = nv / dv;
      rt = nv % dv;
      if (sm) begin
        lo = -(one <<< (w-1));
        hi = (one <<< (w-1)) - one;
      end else begin
        lo = 0;
        hi = mw;
      end
      if (qt < lo || qt > hi) begin
        ov = 1'b1;
        q  = 64'(mw);
        r  = 64'd0;
      end else begin
        q = 64'(qt & mw);
        r = 64'(rt & mw);
      end
    end
  endfunction

  // Transaction-level model: an accepted request produces its result
  // WIDTH+3 edges later; requests while busy are dropped.
  bit          exp_done [2];
  logic [63:0] exp_q    [2];
  logic [63:0] exp_r    [2];
  bit          exp_dz   [2];
  bit          exp_ov   [2];
  bit          busy     [2];
  int          cnt      [2];
  logic [63:0] pend_q   [2];
  logic [63:0] pend_r   [2];
  bit          pend_dz  [2];
  bit          pend_ov  [2];

  always @(posedge clock or posedge reset) begin
    logic [63:0] tq, tr;
    bit tdz, tov;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        exp_done[i] <= 1'b1;
        exp_q[i]    <= '0;
        exp_r[i]    <= '0;
        exp_dz[i]   <= 1'b0;
        exp_ov[i]   <= 1'b0;
        busy[i]     <= 1'b0;
        cnt[i]      <= 0;
      end else if (!busy[i]) begin
        if (in_start[i]) begin
          ref_div(wid(i), in_sm[i], in_num[i], in_den[i], tq, tr, tdz, tov);
          pend_q[i]   <= tq;
          pend_r[i]   <= tr;
          pend_dz[i]  <= tdz;
          pend_ov[i]  <= tov;
          busy[i]     <= 1'b1;
          cnt[i]      <= 1;
          exp_done[i] <= 1'b0;
        end
      end else if (cnt[i] == wid(i) + 3) begin
        busy[i]     <= 1'b0;
        exp_done[i] <= 1'b1;
        exp_q[i]    <= pend_q[i];
        exp_r[i]    <= pend_r[i];
        exp_dz[i]   <= pend_dz[i];
        exp_ov[i]   <= pend_ov[i];
      end else begin
        cnt[i] <= cnt[i] + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("dut%0d_done", i), 64'(out_done[i]), 64'(exp_done[i]));
        chk($sformatf("dut%0d_quotient", i), out_q[i], exp_q[i]);
        chk($sformatf("dut%0d_remainder", i), out_r[i], exp_r[i]);
        chk($sformatf("dut%0d_div_zero", i), 64'(out_dz[i]), 64'(exp_dz[i]));
        chk($sformatf("dut%0d_overflow", i), 64'(out_ov[i]), 64'(exp_ov[i]));
      end
    end
  end

  function automatic void gen_ops(input int w, output bit sm, output logic [127:0] n,
                                  output logic [63:0] d);
    logic [63:0]  mw, v, qq, rr;
    logic [127:0] m2;
    mw = (64'd1 << w) - 64'd1;
    m2 = (128'd1 << (2*w)) - 128'd1;
    sm = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0: d = 64'd0;
      1: d = 64'd1;
      2: d = mw;
      3: d = 64'd1 << (w-1);
      4: d = 64'($urandom_range(2, 20));
      default: d = {$urandom, $urandom} & mw;
    endcase
    v = {$urandom, $urandom} & mw;
    case ($urandom_range(0, 3))
      0: n = {$urandom, $urandom, $urandom, $urandom} & m2;
      1: begin
        n = 128'(v);
        if (sm && v[w-1]) n = (n | ~128'(mw)) & m2;
      end
      2: begin
        qq = {$urandom, $urandom} & (mw >> 1);
        rr = {$urandom, $urandom} & mw;
        if (d != 0) rr = rr % d;
        n = (128'(d) * 128'(qq) + 128'(rr)) & m2;
        if (sm && $urandom_range(0, 1) == 1) n = (-n) & m2;
      end
      default: n = 128'd1 << (2*w-1);
    endcase
  endfunction

  task automatic run_a(input string nm, input bit sm, input logic [63:0] n, input logic [31:0] d,
                       input logic [31:0] eq, input logic [31:0] er, input bit edz, input bit eov,
                       input int poke);
    int edges;
    @(negedge clock);
    sm_a = sm; num_a = n; den_a = d; start_a = 1'b1;
    @(posedge clock); #1;
    chk({nm, "_accept"}, 64'(done_a), 64'd0);
    start_a = 1'b0;
    num_a = {$urandom, $urandom}; den_a = $urandom; sm_a = ~sm;
    edges = 0;
    do begin
      @(posedge clock); #1;
      edges++;
      start_a = (edges == poke);
    end while (!done_a && edges < 200);
    start_a = 1'b0;
    chk({nm, "_latency"}, 64'(edges), 64'(WA + 3));
    chk({nm, "_q"}, 64'(q_a), 64'(eq));
    chk({nm, "_r"}, 64'(r_a), 64'(er));
    chk({nm, "_dz"}, 64'(dz_a), 64'(edz));
    chk({nm, "_ovf"}, 64'(ov_a), 64'(eov));
  endtask

  task automatic wait_done_a(output int edges);
    edges = 0;
    do begin
      @(posedge clock); #1;
      edges++;
    end while (!done_a && edges < 200);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] mq, mr;
    bit mdz, mov;
    int edges;

    tests = 0; failed = 0; checking = 1'b0;
    reset = 1'b0;
    start_a = 0; sm_a = 0; num_a = '0; den_a = '0;
    start_b = 0; sm_b = 0; num_b = '0; den_b = '0;

    // pin the reference model against hand-computed results
    ref_div(32, 1'b1, 128'hFFFFFFFF_FFFFFFF9, 64'd2, mq, mr, mdz, mov);
    chk("model_s_m7_2_q", mq, 64'hFFFFFFFD);
    chk("model_s_m7_2_r", mr, 64'hFFFFFFFF);
    ref_div(32, 1'b0, 128'hFFFFFFFE_FFFFFFFF, 64'hFFFFFFFF, mq, mr, mdz, mov);
    chk("model_u_max_q", mq, 64'hFFFFFFFF);
    chk("model_u_max_r", mr, 64'hFFFFFFFE);
    ref_div(32, 1'b1, 128'hFFFFFFFF_80000000, 64'hFFFFFFFF, mq, mr, mdz, mov);
    chk("model_s_ovf", 64'(mov), 64'd1);
    ref_div(8, 1'b0, 128'd200, 64'd7, mq, mr, mdz, mov);
    chk("model_w8_q", mq, 64'd28);
    chk("model_w8_r", mr, 64'd4);
    ref_div(8, 1'b1, 128'hFF80, 64'hFF, mq, mr, mdz, mov);
    chk("model_w8_s_ovf", 64'(mov), 64'd1);
    ref_div(32, 1'b0, 128'd100, 64'd0, mq, mr, mdz, mov);
    chk("model_dz_r", mr, 64'd100);

    #1 reset = 1'b1;
    #1 checking = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    run_a("u7_2",      1'b0, 64'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b0, 0);
    run_a("u3550_113", 1'b0, 64'd3550, 32'd113, 32'd31, 32'd47, 1'b0, 1'b0, 0);
    run_a("u_max",     1'b0, 64'hFFFFFFFE_FFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 0);
    run_a("s_m7_2",    1'b1, 64'hFFFFFFFF_FFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    run_a("s_7_m2",    1'b1, 64'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0, 0);
    run_a("s_m7_m2",   1'b1, 64'hFFFFFFFF_FFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    run_a("div_zero",  1'b0, 64'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 1'b1, 1'b0, 0);
    run_a("u_ovf",     1'b0, 64'h1_00000000, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 0);
    run_a("s_ovf",     1'b1, 64'hFFFFFFFF_80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 0);
    run_a("s_minq",    1'b1, 64'hFFFFFFFF_80000000, 32'd1, 32'h80000000, 32'd0, 1'b0, 1'b0, 0);
    run_a("ignore",    1'b0, 64'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b0, 10);

    // back-to-back with start held high
    @(negedge clock);
    sm_a = 1'b0; num_a = 64'd100; den_a = 32'd7; start_a = 1'b1;
    @(posedge clock); #1;
    num_a = 64'd3550; den_a = 32'd113;
    wait_done_a(edges);
    chk("b2b_latency1", 64'(edges), 64'(WA + 3));
    chk("b2b_q1", 64'(q_a), 64'd14);
    chk("b2b_r1", 64'(r_a), 64'd2);
    @(posedge clock); #1;
    chk("b2b_accept2", 64'(done_a), 64'd0);
    chk("b2b_hold_q1", 64'(q_a), 64'd14);
    start_a = 1'b0;
    wait_done_a(edges);
    chk("b2b_latency2", 64'(edges), 64'(WA + 3));
    chk("b2b_q2", 64'(q_a), 64'd31);
    chk("b2b_r2", 64'(r_a), 64'd47);

    // reset mid-operation
    @(negedge clock);
    sm_a = 1'b0; num_a = 64'd7; den_a = 32'd2; start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    repeat (12) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("rst_done", 64'(done_a), 64'd1);
    chk("rst_q", 64'(q_a), 64'd0);
    chk("rst_r", 64'(r_a), 64'd0);
    chk("rst_dz", 64'(dz_a), 64'd0);
    chk("rst_ovf", 64'(ov_a), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    run_a("post_reset", 1'b0, 64'd100, 32'd17, 32'd5, 32'd15, 1'b0, 1'b0, 0);

    // randomised traffic on both widths
    fork
      begin
        bit s; logic [127:0] n; logic [63:0] d;
        repeat (RAND_CYCLES) begin
          @(negedge clock);
          gen_ops(WA, s, n, d);
          sm_a = s; num_a = n[63:0]; den_a = d[31:0];
          start_a = ($urandom_range(0, 3) != 0);
        end
        @(negedge clock);
        start_a = 1'b0;
      end
      begin
        bit s; logic [127:0] n; logic [63:0] d;
        repeat (RAND_CYCLES) begin
          @(negedge clock);
          gen_ops(WB, s, n, d);
          sm_b = s; num_b = n[15:0]; den_b = d[7:0];
          start_b = ($urandom_range(0, 3) != 0);
        end
        @(negedge clock);
        start_b = 1'b0;
      end
    join

    repeat (WA + 10) @(negedge clock);
    chk("final_idle_a", 64'(done_a), 64'd1);
    chk("final_idle_b", 64'(done_b), 64'd1);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
